// File: rtl/ct_cc_pkg.sv
// Shared definitions for the clock-crossing FIFO read and write controllers:
// default geometry and Gray/binary pointer conversion helpers.
package ct_cc_pkg;

    localparam int CC_ADDR_WIDTH  = 5;
    localparam int CC_SYNC_STAGES = 3;
    localparam int CC_PTR_MAXW    = 32;

    // Pointers of any width up to CC_PTR_MAXW are zero-extended into this
    // type. The conversions stay exact in the low bits because the
    // zero-extended upper bits contribute nothing.
    typedef logic [CC_PTR_MAXW-1:0] cc_ptr_t;

    function automatic cc_ptr_t bin2gray(input cc_ptr_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic cc_ptr_t gray2bin(input cc_ptr_t g);
        cc_ptr_t b;
        b[CC_PTR_MAXW-1] = g[CC_PTR_MAXW-1];
        for (int i = CC_PTR_MAXW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/ct_cc_rd_ctrl_if.sv
// Read-side bundle of the clock-crossing FIFO: pointer exchange with the
// write domain, the RAM read port and the valid/ready consumer port.
interface ct_cc_rd_ctrl_if #(
    parameter int WIDTH      = 1,
    parameter int ADDR_WIDTH = 5
);
    logic [ADDR_WIDTH:0]   i_wrgray;
    logic [ADDR_WIDTH:0]   o_rdgray;
    logic [ADDR_WIDTH-1:0] o_ram_addr;
    logic                  o_ram_rden;
    logic [WIDTH-1:0]      i_ram_data;
    logic [WIDTH-1:0]      o_data;
    logic                  o_valid;
    logic                  i_ready;
    logic [ADDR_WIDTH:0]   o_rdusedw;

    // Read controller side
    modport master (
        input  i_wrgray, i_ram_data, i_ready,
        output o_rdgray, o_ram_addr, o_ram_rden, o_data, o_valid, o_rdusedw
    );

    // RAM / write side / consumer
    modport slave (
        output i_wrgray, i_ram_data, i_ready,
        input  o_rdgray, o_ram_addr, o_ram_rden, o_data, o_valid, o_rdusedw
    );
endinterface

// File: rtl/ct_cc_sync.sv
// Multi-bit flop-chain synchronizer. Only safe for Gray-coded buses where at
// most one bit changes per source clock. chain_q[0] is the false-path target.
module ct_cc_sync #(
    parameter int W      = 6,
    parameter int STAGES = 3   // must be >= 2
) (
    input  logic         clk,
    input  logic         arst,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o,
    output logic [W-1:0] q_nx_o
);
    logic [STAGES-1:0][W-1:0] chain_q;

    // Shift the asynchronous bus through the chain
    always_ff @(posedge clk or posedge arst) begin
        if (arst) chain_q <= '0;
        else      chain_q <= {chain_q[STAGES-2:0], d_i};
    end

    assign q_o    = chain_q[STAGES-1];
    // Value the output stage loads on the next edge
    assign q_nx_o = chain_q[STAGES-2];
endmodule

// File: rtl/ct_cc_rd_ctrl.sv
// Read-side controller of a dual-clock FIFO. Synchronizes the write pointer,
// issues RAM reads while the FIFO is non-empty, and hides the one-cycle RAM
// latency with a 2-entry skid buffer so a word can be delivered every cycle.
module ct_cc_rd_ctrl
    import ct_cc_pkg::*;
#(
    parameter int WIDTH       = 1,
    parameter int ADDR_WIDTH  = CC_ADDR_WIDTH,
    parameter int SYNC_STAGES = CC_SYNC_STAGES
) (
    input logic             rdclk,
    input logic             rdarst,
    ct_cc_rd_ctrl_if.master rd
);
    localparam int             PW      = ADDR_WIDTH + 1;
    localparam logic [PW-1:0]  PTR_ONE = PW'(1);

    logic [PW-1:0] sync_wrgray, sync_wrgray_nx;
    logic [PW-1:0] sync_wrbin, sync_wrbin_nx;

    logic [PW-1:0] rdbin_q, rdbin_d;
    logic [PW-1:0] rdgray_q, rdgray_d;
    logic [PW-1:0] rdusedw_q, rdusedw_d;

    logic                  rd_vld_q;         // RAM read in flight
    logic [1:0][WIDTH-1:0] buf_q;
    logic                  buf_wp_q, buf_wp_d;
    logic                  buf_rp_q, buf_rp_d;
    logic [1:0]            buf_cnt_q, buf_cnt_d;
    logic [1:0]            entries;

    logic empty, xfer, rden;

    ct_cc_sync #(
        .W      (PW),
        .STAGES (SYNC_STAGES)
    ) u_wrsync (
        .clk    (rdclk),
        .arst   (rdarst),
        .d_i    (rd.i_wrgray),
        .q_o    (sync_wrgray),
        .q_nx_o (sync_wrgray_nx)
    );

    assign sync_wrbin    = PW'(gray2bin(cc_ptr_t'(sync_wrgray)));
    assign sync_wrbin_nx = PW'(gray2bin(cc_ptr_t'(sync_wrgray_nx)));

    // Only registered state feeds empty, so a pointer arriving this cycle
    // cannot trigger a read until it has been loaded into the last stage.
    assign empty   = (rdbin_q == sync_wrbin);
    assign entries = buf_cnt_q + {1'b0, rd_vld_q};
    assign xfer    = rd.o_valid & rd.i_ready;
    // Credit: at most two words held or in flight; a transfer frees one now
    assign rden    = !empty && ((entries < 2'd2) || xfer);

    // Next-state of the read pointer and the values registered from it
    always_comb begin
        rdbin_d   = rden ? (rdbin_q + PTR_ONE) : rdbin_q;
        rdgray_d  = PW'(bin2gray(cc_ptr_t'(rdbin_d)));
        // Pair the post-edge synchronized write pointer with the post-edge
        // read pointer so the registered count matches the registered state.
        rdusedw_d = sync_wrbin_nx - rdbin_d;
    end

    // Skid buffer bookkeeping: capture one cycle after rden, pop on transfer
    always_comb begin
        buf_wp_d  = buf_wp_q ^ rd_vld_q;
        buf_rp_d  = buf_rp_q ^ xfer;
        buf_cnt_d = buf_cnt_q;
        case ({rd_vld_q, xfer})
            2'b10:   buf_cnt_d = buf_cnt_q + 2'd1;
            2'b01:   buf_cnt_d = buf_cnt_q - 2'd1;
            default: buf_cnt_d = buf_cnt_q;
        endcase
    end

    // Pointer, credit and buffer control state
    always_ff @(posedge rdclk or posedge rdarst) begin
        if (rdarst) begin
            rdbin_q   <= '0;
            rdgray_q  <= '0;
            rdusedw_q <= '0;
            rd_vld_q  <= 1'b0;
            buf_wp_q  <= 1'b0;
            buf_rp_q  <= 1'b0;
            buf_cnt_q <= '0;
        end else begin
            rdbin_q   <= rdbin_d;
            rdgray_q  <= rdgray_d;
            rdusedw_q <= rdusedw_d;
            rd_vld_q  <= rden;
            buf_wp_q  <= buf_wp_d;
            buf_rp_q  <= buf_rp_d;
            buf_cnt_q <= buf_cnt_d;
        end
    end

    // Buffer storage carries no reset; validity comes from buf_cnt_q
    always_ff @(posedge rdclk) begin
        if (rd_vld_q) buf_q[buf_wp_q] <= rd.i_ram_data;
    end

    assign rd.o_rdgray   = rdgray_q;
    assign rd.o_rdusedw  = rdusedw_q;
    assign rd.o_ram_addr = rdbin_q[ADDR_WIDTH-1:0];
    assign rd.o_ram_rden = rden;
    assign rd.o_valid    = (buf_cnt_q != 2'd0);
    assign rd.o_data     = buf_q[buf_rp_q];

endmodule

// File: doc/ct_cc_rd_ctrl.md
CT_CC_RD_CTRL -- requirements
Module: ct_cc_rd_ctrl

Interface
REQ-001 Parameter WIDTH, default 1: data word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 5: RAM address width; FIFO depth is 2^ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.
REQ-003 Parameter SYNC_STAGES, default 3: flop stages in the write-pointer synchronizer, minimum 2.
REQ-004 rdclk  input  1  read-domain clock; all state is in this domain.
REQ-005 rdarst  input  1  reset, asynchronous, active-high.
REQ-006 i_wrgray  input  ADDR_WIDTH+1  write pointer, Gray-coded and registered in the write domain; asynchronous to rdclk.
REQ-007 o_rdgray  output  ADDR_WIDTH+1  read pointer, Gray-coded and registered, returned to the write domain.
REQ-008 o_ram_addr  output  ADDR_WIDTH  RAM read address, equal to rdbin[ADDR_WIDTH-1:0].
REQ-009 o_ram_rden  output  1  RAM read strobe; one word is consumed per asserted cycle.
REQ-010 i_ram_data  input  WIDTH  RAM read data, valid exactly one rdclk cycle after o_ram_rden.
REQ-011 o_data  output  WIDTH  head-of-queue word.
REQ-012 o_valid  output  1  o_data valid.
REQ-013 i_ready  input  1  consumer accepts o_data; transfer occurs when o_valid and i_ready are both high.
REQ-014 o_rdusedw  output  ADDR_WIDTH+1  registered count of words written but not yet issued to RAM.

Function
REQ-015 i_wrgray passes through SYNC_STAGES flops; the last stage output is sync_wrgray, converted to binary sync_wrbin.
REQ-016 empty is high when rdbin == sync_wrbin; empty is combinational from registered state.
REQ-017 Credit: entries = words held in output buffer + words in flight from RAM; range 0..2.
REQ-018 o_ram_rden is high iff !empty and (entries < 2 or a transfer occurs this cycle).
REQ-019 On o_ram_rden, rdbin increments by 1 modulo 2^(ADDR_WIDTH+1) and o_rdgray is loaded with bin2gray(rdbin+1) on the same edge.
REQ-020 The output buffer is a 2-entry in-order FIFO capturing i_ram_data on the edge ending the cycle after o_ram_rden.
REQ-021 Latency: o_ram_rden in cycle T gives o_valid at earliest in cycle T+2 (buffer empty); steady-state throughput is one word per cycle with i_ready held high.
REQ-022 o_valid and o_data present the oldest buffered word; they hold stable while o_valid and !i_ready.
REQ-023 Capture and transfer in the same cycle are both honoured; word order is strictly preserved.
REQ-024 o_rdusedw is registered as (sync_wrbin - rdbin_next) modulo 2^(ADDR_WIDTH+1); range 0..2^ADDR_WIDTH.
REQ-025 Wrap-around: pointer wrap from 2^(ADDR_WIDTH+1)-1 to 0 produces no spurious empty, count or address discontinuity.
REQ-026 o_ram_rden is never asserted while empty, including the cycle sync_wrgray changes.

Reset
REQ-027 rdarst asynchronously clears rdbin, o_rdgray, synchronizer flops, buffer and credit state to 0; o_valid = 0, o_ram_rden = 0, o_rdusedw = 0.
REQ-028 o_data is not reset; it is don't-care while o_valid = 0.
REQ-029 Reset mid-operation discards buffered and in-flight words; no stale word appears after release.
REQ-030 rdarst deassertion is synchronized to rdclk by the instantiator; the write side is reset concurrently.

Structure
REQ-031 Package ct_cc_pkg holds bin2gray/gray2bin functions and default ADDR_WIDTH/SYNC_STAGES constants, shared with the write-side controller.
REQ-032 Sub-module ct_cc_sync, a parameterised multi-bit flop-chain synchronizer, implements REQ-015; its first stage is a false-path target.

Verification (ADDR_WIDTH=5, SYNC_STAGES=3)
REQ-033 Assert rdarst during traffic -> o_valid, o_ram_rden, o_rdgray, o_rdusedw = 0 immediately; no old data after release.
REQ-034 i_wrgray 0->1, i_ready=1 -> o_ram_rden with addr 0 in the cycle after the 3rd sampling edge; o_rdgray = 1 next edge; o_valid two cycles after rden.
REQ-035 i_wrgray = gray(32) = 6'b110000 -> 32 back-to-back reads addr 0..31; o_valid continuous; o_rdusedw 32 down to 0; o_rdgray ends at 6'b110000.
REQ-036 10 words available, i_ready=0 -> exactly 2 rden pulses; o_data stable; on i_ready=1 all 10 words delivered in order.
REQ-037 Pointers preloaded to 60, writer advances to 68 (4 wraps to 4) -> addresses 28,29,30,31,0,1,2,3; rdbin 63->0; correct Gray on o_rdgray.
REQ-038 Random i_ready and i_wrgray increments, 10k words -> scoreboard matches, no read when empty, entries never exceed 2.
